// File: rtl/playmode_layer_mux.sv
// Play-mode compositor: merges the background colour with the HUD, ball,
// player and rope layers by fixed priority and registers the RGB332 result.
// A hit-flash FSM inverts the play-field colours (never the HUD) in blink
// phases for a fixed number of frames after the player is hit.
module playmode_layer_mux #(
  parameter int          FLASH_FRAMES = 32,
  parameter int          BLINK_PERIOD = 4,
  parameter logic [7:0]  TRANSPARENT  = 8'hFF
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       hitPulse,
  input  logic       hudDR,
  input  logic [7:0] hudRGB,
  input  logic       ballDR,
  input  logic [7:0] ballRGB,
  input  logic       playerDR,
  input  logic [7:0] playerRGB,
  input  logic       ropeDR,
  input  logic [7:0] ropeRGB,
  input  logic [7:0] BG_RGB,
  output logic [7:0] RGBOut,
  output logic       flashActive
);

  localparam int FW = $clog2(FLASH_FRAMES);
  localparam int BW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FLASH_FRAMES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLASH = 1'b1;

  logic [0:0]    state, state_next;
  logic [FW-1:0] frame_cnt, frame_next;
  logic [BW-1:0] blink_cnt, blink_next;
  logic          phase, phase_next;

  logic          hud_valid, ball_valid, player_valid, rope_valid;
  logic [7:0]    sel_rgb;
  logic          sel_is_hud;
  logic          invert;
  logic [7:0]    pix_next;

  // Flash FSM next state: a hit always restarts the flash and beats any frame count
  always_comb begin
    state_next = state;
    frame_next = frame_cnt;
    blink_next = blink_cnt;
    phase_next = phase;
    if (hitPulse) begin
      state_next = FLASH;
      frame_next = '0;
      blink_next = '0;
      phase_next = 1'b1;
    end else if (state == FLASH && startOfFrame) begin
      if (frame_cnt == FRAME_LAST) begin
        state_next = IDLE;
        frame_next = '0;
        blink_next = '0;
        phase_next = 1'b0;
      end else begin
        frame_next = frame_cnt + 1'b1;
        if (blink_cnt == BLINK_LAST) begin
          blink_next = '0;
          phase_next = ~phase;
        end else begin
          blink_next = blink_cnt + 1'b1;
        end
      end
    end
  end

  // Priority select of the visible layer, inverted during the flash's inverted phase
  always_comb begin
    hud_valid    = hudDR    && (hudRGB    != TRANSPARENT);
    ball_valid   = ballDR   && (ballRGB   != TRANSPARENT);
    player_valid = playerDR && (playerRGB != TRANSPARENT);
    rope_valid   = ropeDR   && (ropeRGB   != TRANSPARENT);
    sel_is_hud   = 1'b0;
    if (hud_valid) begin
      sel_rgb    = hudRGB;
      sel_is_hud = 1'b1;
    end else if (ball_valid) begin
      sel_rgb = ballRGB;
    end else if (player_valid) begin
      sel_rgb = playerRGB;
    end else if (rope_valid) begin
      sel_rgb = ropeRGB;
    end else begin
      sel_rgb = BG_RGB;
    end
    invert   = (state == FLASH) && phase && !sel_is_hud;
    pix_next = invert ? ~sel_rgb : sel_rgb;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      frame_cnt   <= '0;
      blink_cnt   <= '0;
      phase       <= 1'b0;
      RGBOut      <= 8'h00;
      flashActive <= 1'b0;
    end else begin
      state       <= state_next;
      frame_cnt   <= frame_next;
      blink_cnt   <= blink_next;
      phase       <= phase_next;
      RGBOut      <= pix_next;
      flashActive <= (state_next == FLASH);
    end
  end

endmodule

// File: tb/tb_playmode_layer_mux.sv
// Directed bench for playmode_layer_mux: layer priority, transparency,
// flash blink timing, HUD immunity, restart behaviour and async reset.
module tb_playmode_layer_mux;

  logic       clk;
  logic       resetN;
  logic       startOfFrame;
  logic       hitPulse;
  logic       hudDR;
  logic [7:0] hudRGB;
  logic       ballDR;
  logic [7:0] ballRGB;
  logic       playerDR;
  logic [7:0] playerRGB;
  logic       ropeDR;
  logic [7:0] ropeRGB;
  logic [7:0] BG_RGB;
  logic [7:0] RGBOut;
  logic       flashActive;

  int checks   = 0;
  int failures = 0;

  playmode_layer_mux #(
    .FLASH_FRAMES(32),
    .BLINK_PERIOD(4),
    .TRANSPARENT(8'hFF)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .hitPulse(hitPulse),
    .hudDR(hudDR),
    .hudRGB(hudRGB),
    .ballDR(ballDR),
    .ballRGB(ballRGB),
    .playerDR(playerDR),
    .playerRGB(playerRGB),
    .ropeDR(ropeDR),
    .ropeRGB(ropeRGB),
    .BG_RGB(BG_RGB),
    .RGBOut(RGBOut),
    .flashActive(flashActive)
  );

  // Free-running pixel clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and land 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One startOfFrame pulse, then one more cycle so RGBOut shows the new phase
  task automatic sofPulse(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
    end
  endtask

  // One-cycle hit pulse
  task automatic applyStimulus();
    hitPulse = 1'b1;
    tick();
    hitPulse = 1'b0;
  endtask

  // Compare both outputs against hand-computed expectations
  task automatic checkOutput(input string tag, input logic [7:0] exp_rgb, input logic exp_flash);
    checks++;
    assert (RGBOut === exp_rgb) else begin
      failures++;
      $error("[TB] FAIL %s RGBOut got=%h exp=%h", tag, RGBOut, exp_rgb);
    end
    checks++;
    assert (flashActive === exp_flash) else begin
      failures++;
      $error("[TB] FAIL %s flashActive got=%b exp=%b", tag, flashActive, exp_flash);
    end
  endtask

  initial begin
    resetN = 1'b1;
    startOfFrame = 1'b0; hitPulse = 1'b0;
    hudDR = 1'b0; hudRGB = 8'h00;
    ballDR = 1'b0; ballRGB = 8'h00;
    playerDR = 1'b0; playerRGB = 8'h00;
    ropeDR = 1'b0; ropeRGB = 8'h00;
    BG_RGB = 8'hE0;

    #2 resetN = 1'b0;
    #1 checkOutput("reset_async", 8'h00, 1'b0);
    tick();
    tick();
    checkOutput("reset_held", 8'h00, 1'b0);
    resetN = 1'b1;
    tick();
    checkOutput("bg_after_reset", 8'hE0, 1'b0);

    $display("[TB] priority");
    ropeDR = 1'b1;   ropeRGB = 8'h1C;
    playerDR = 1'b1; playerRGB = 8'h03;
    ballDR = 1'b1;   ballRGB = 8'hFC;
    hudDR = 1'b1;    hudRGB = 8'h92;
    tick(); checkOutput("prio_hud", 8'h92, 1'b0);
    hudDR = 1'b0;
    tick(); checkOutput("prio_ball", 8'hFC, 1'b0);
    ballDR = 1'b0;
    tick(); checkOutput("prio_player", 8'h03, 1'b0);
    playerDR = 1'b0;
    tick(); checkOutput("prio_rope", 8'h1C, 1'b0);
    ropeDR = 1'b0;
    tick(); checkOutput("prio_bg", 8'hE0, 1'b0);

    $display("[TB] transparency");
    ballDR = 1'b1; ballRGB = 8'hFF;
    playerDR = 1'b1; playerRGB = 8'h03;
    tick(); checkOutput("transp_ball", 8'h03, 1'b0);
    playerDR = 1'b0;
    tick(); checkOutput("transp_to_bg", 8'hE0, 1'b0);
    ballDR = 1'b0;
    hudDR = 1'b1; hudRGB = 8'hFF;
    ropeDR = 1'b1; ropeRGB = 8'h1C;
    tick(); checkOutput("transp_hud", 8'h1C, 1'b0);
    hudDR = 1'b0; ropeDR = 1'b0;
    tick(); checkOutput("idle_sof_ignored_pre", 8'hE0, 1'b0);
    sofPulse(2);
    checkOutput("idle_sof_ignored", 8'hE0, 1'b0);

    $display("[TB] flash timing");
    applyStimulus();
    checkOutput("hit_edge", 8'hE0, 1'b1);
    tick(); checkOutput("hit_inverted", 8'h1F, 1'b1);
    sofPulse(3); checkOutput("flash_sof3", 8'h1F, 1'b1);
    sofPulse(1); checkOutput("flash_sof4", 8'hE0, 1'b1);
    sofPulse(3); checkOutput("flash_sof7", 8'hE0, 1'b1);
    sofPulse(1); checkOutput("flash_sof8", 8'h1F, 1'b1);
    sofPulse(23); checkOutput("flash_sof31", 8'hE0, 1'b1);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    checkOutput("flash_sof32_edge", 8'hE0, 1'b0);
    tick(); checkOutput("flash_done", 8'hE0, 1'b0);
    sofPulse(4); checkOutput("flash_stays_idle", 8'hE0, 1'b0);

    $display("[TB] hud immunity");
    applyStimulus();
    tick(); checkOutput("imm_start", 8'h1F, 1'b1);
    hudDR = 1'b1; hudRGB = 8'h92;
    tick(); checkOutput("imm_hud", 8'h92, 1'b1);
    hudDR = 1'b0; ballDR = 1'b1; ballRGB = 8'hFC;
    tick(); checkOutput("imm_ball_inv", 8'h03, 1'b1);
    ballDR = 1'b0; playerDR = 1'b1; playerRGB = 8'h03;
    tick(); checkOutput("imm_player_inv", 8'hFC, 1'b1);
    playerDR = 1'b0;
    tick();

    $display("[TB] restart");
    sofPulse(20); checkOutput("rs_frame20", 8'hE0, 1'b1);
    applyStimulus();
    tick(); checkOutput("rs_hit", 8'h1F, 1'b1);
    sofPulse(5);
    hitPulse = 1'b1; startOfFrame = 1'b1;
    tick();
    hitPulse = 1'b0; startOfFrame = 1'b0;
    tick(); checkOutput("rs_hit_sof", 8'h1F, 1'b1);
    sofPulse(3); checkOutput("rs_sof3", 8'h1F, 1'b1);
    sofPulse(1); checkOutput("rs_sof4", 8'hE0, 1'b1);
    sofPulse(27); checkOutput("rs_sof31", 8'hE0, 1'b1);
    sofPulse(1); checkOutput("rs_sof32", 8'hE0, 1'b0);

    $display("[TB] reset mid-flash");
    applyStimulus();
    tick();
    sofPulse(10); checkOutput("mid_frame10", 8'h1F, 1'b1);
    #2 resetN = 1'b0;
    #1 checkOutput("mid_async_reset", 8'h00, 1'b0);
    tick();
    resetN = 1'b1;
    tick(); checkOutput("mid_release", 8'hE0, 1'b0);
    sofPulse(4); checkOutput("mid_no_resume", 8'hE0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/playmode_layer_mux.md
Name: playmode_layer_mux

Overview:
Compositor stage directly downstream of the play-mode background generator. Each pixel clock it merges the background colour with the drawing requests of the game-object layers (HUD, balls, player, rope) by fixed priority. It produces the registered 8-bit RGB332 pixel sent to the VGA output stage. A hit-flash state machine inverts the play-field colours for a fixed number of frames after a player hit.

Parameters:
FLASH_FRAMES, 32, total frames the hit flash lasts (>=2)
BLINK_PERIOD, 4, frames per blink phase during flash (>=1)
TRANSPARENT, 8'hFF, layer colour treated as "no draw" even when request is high

Ports:
clk  in  1  pixel clock
resetN  in  1  async active-low reset
startOfFrame  in  1  one-cycle pulse at first pixel of each frame
hitPulse  in  1  one-cycle pulse: player hit by ball
hudDR  in  1  HUD/score digits drawing request
hudRGB  in  8  HUD colour
ballDR  in  1  balls drawing request
ballRGB  in  8  ball colour
playerDR  in  1  player drawing request
playerRGB  in  8  player colour
ropeDR  in  1  rope drawing request
ropeRGB  in  8  rope colour
BG_RGB  in  8  background colour, RGB332
RGBOut  out  8  composited pixel, RGB332, registered
flashActive  out  1  high while flash FSM is in FLASH, registered

Behaviour:
- Reset is resetN, asynchronous, active-low; clock is clk. On reset: RGBOut=8'h00, flashActive=0, state=IDLE, frameCnt=0, blinkCnt=0, phase=0.
- Layer valid = xxDR && (xxRGB != TRANSPARENT).
- Priority, highest first: hud > ball > player > rope > BG_RGB. The background is always valid.
- Latency: exactly 1 clk. RGBOut at edge t+1 reflects the inputs in cycle t and the FSM state/phase held during cycle t, before that edge's update.
- Inversion: the selected colour is bitwise inverted (~rgb) when state==FLASH && phase==1 && the selected layer is not hud. HUD colours are never inverted.
- FSM states:
  - IDLE: on hitPulse go to FLASH with frameCnt=0, blinkCnt=0, phase=1. startOfFrame is ignored in IDLE.
  - FLASH: on startOfFrame:
    - If frameCnt==FLASH_FRAMES-1, go to IDLE and clear all counters and phase.
    - Otherwise frameCnt++ and blinkCnt++.
    - When blinkCnt==BLINK_PERIOD-1, blinkCnt wraps to 0 and phase toggles.
  - A hitPulse while in FLASH restarts the flash: frameCnt=0, blinkCnt=0, phase=1.
- Simultaneous hitPulse and startOfFrame in the same cycle: the restart wins and no count is applied.
- Counter widths: frameCnt uses $clog2(FLASH_FRAMES) bits; blinkCnt uses $clog2(BLINK_PERIOD) bits, minimum 1. Neither counter ever exceeds its terminal value.
- flashActive is registered and equals (next state==FLASH). It rises on the edge that samples hitPulse.
- With BLINK_PERIOD=1, phase toggles on every startOfFrame.
- Reset mid-flash returns immediately to the reset values. No flash resumes after reset release.

Test Plan:
1. Priority: BG=8'hE0; set ropeDR=1/ropeRGB=8'h1C, playerDR=1/playerRGB=8'h03, ballDR=1/ballRGB=8'hFC, hudDR=1/hudRGB=8'h92. Drop each request highest-first. -> RGBOut sequence 8'h92, 8'hFC, 8'h03, 8'h1C, 8'hE0, each one cycle after the change.
2. Transparency: ballDR=1 with ballRGB=8'hFF, playerDR=1 with playerRGB=8'h03. -> RGBOut=8'h03. Drop playerDR with BG=8'hE0. -> RGBOut=8'hE0.
3. Flash timing (FLASH_FRAMES=32, BLINK_PERIOD=4): pulse hitPulse with BG=8'hE0 and no layers. -> RGBOut=8'h1F. After 4 startOfFrame pulses -> 8'hE0. After 8 pulses -> 8'h1F. Pulse 32 -> flashActive=0 and RGBOut=8'hE0 thereafter.
4. HUD immunity: during an inverted phase, hudDR=1 with hudRGB=8'h92. -> RGBOut=8'h92. ballDR=1 with ballRGB=8'hFC instead. -> RGBOut=8'h03.
5. Restart: hitPulse at frame 20 of a flash, then hitPulse and startOfFrame in the same cycle. -> frameCnt=0, phase=1, and the flash ends exactly 32 startOfFrame pulses after the last hitPulse.
6. Reset mid-flash: assert resetN=0 asynchronously (between clock edges) at frame 10. -> RGBOut=8'h00 and flashActive=0 without waiting for a clock. After release with BG=8'hE0 -> RGBOut=8'hE0, not inverted.
